// File: rtl/config_loader_pkg.sv
// Shared types and field positions for the fabric configuration loader.
// Header and address word layouts live here so tiles and loader agree.
package config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_ISSUE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hC0F1;

    localparam int TILE_ID_LSB  = 0;
    localparam int TILE_ID_MSB  = 15;
    localparam int BLOCK_ID_LSB = 16;
    localparam int BLOCK_ID_MSB = 31;

    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_COUNT_LSB = 0;
    localparam int HDR_COUNT_MSB = 15;

    function automatic logic [15:0] tile_id(input logic [31:0] addr);
        return addr[TILE_ID_MSB:TILE_ID_LSB];
    endfunction

    function automatic logic [15:0] block_id(input logic [31:0] addr);
        return addr[BLOCK_ID_MSB:BLOCK_ID_LSB];
    endfunction

    function automatic logic [15:0] hdr_magic(input logic [31:0] word);
        return word[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    endfunction

    function automatic logic [15:0] hdr_count(input logic [31:0] word);
        return word[HDR_COUNT_MSB:HDR_COUNT_LSB];
    endfunction

endpackage

// File: rtl/config_gap_timer.sv
// Loadable down-counter with a zero flag; times the settle gap between writes.
// Load wins over decrement; the count parks at zero.
module config_gap_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/config_loader.sv
// Parses a magic/count header then address/data pairs from a word stream and
// drives the shared tile config bus with one strobe per pair plus a settle gap.
module config_loader
    import config_loader_pkg::*;
#(
    parameter logic [15:0] MAGIC      = MAGIC_DEFAULT,
    parameter int          GAP_CYCLES = 2,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      config_addr,
    output logic [31:0]      config_data,
    output logic             config_en,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] writes_done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // The ISSUE cycle loads the timer, so GAP sees GAP_CYCLES-1 down to 0.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_remain;
    logic [CNT_W-1:0] r_writes;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;

    logic w_xfer;
    logic w_start_ok;
    logic w_magic_ok;
    logic w_gap_load;
    logic w_gap_dec;
    logic w_gap_zero;

    assign w_xfer     = in_valid && in_ready;
    assign w_start_ok = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign w_magic_ok = (hdr_magic(in_data) == MAGIC);
    assign w_gap_load = (r_state == ST_ISSUE);
    assign w_gap_dec  = (r_state == ST_GAP);

    config_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_next = ST_HDR;
            end
            ST_HDR: begin
                if (in_valid) begin
                    if (!w_magic_ok)                  w_next = ST_ERR;
                    else if (hdr_count(in_data) == 0) w_next = ST_DONE;
                    else                              w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (in_valid) w_next = ST_DATA;
            end
            ST_DATA: begin
                if (in_valid) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                // r_remain still counts the pair being written here.
                if (GAP_CYCLES > 0)         w_next = ST_GAP;
                else if (r_remain == 16'd1) w_next = ST_DONE;
                else                        w_next = ST_ADDR;
            end
            ST_GAP: begin
                if (w_gap_zero) w_next = (r_remain == 16'd0) ? ST_DONE : ST_ADDR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        config_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            ST_HDR, ST_ADDR, ST_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_ISSUE: begin
                config_en = 1'b1;
                busy      = 1'b1;
            end
            ST_GAP:  busy  = 1'b1;
            ST_DONE: done  = 1'b1;
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_remain <= '0;
            r_writes <= '0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            if (w_start_ok) begin
                r_writes <= '0;
            end
            if (w_xfer && (r_state == ST_HDR) && w_magic_ok) begin
                r_remain <= hdr_count(in_data);
            end
            if (w_xfer && (r_state == ST_ADDR)) begin
                r_addr <= in_data;
            end
            if (w_xfer && (r_state == ST_DATA)) begin
                r_data <= in_data;
            end
            if (r_state == ST_ISSUE) begin
                r_writes <= r_writes + 1'b1;
                r_remain <= r_remain - 16'd1;
            end
        end
    end

    assign config_addr = r_addr;
    assign config_data = r_data;
    assign writes_done = r_writes;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a transaction-level model per instance
// (settle gap of 2 and of 0) compared against the DUT outputs every cycle.
module tb_config_loader;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_DONE = 2;
    localparam int P_ERR  = 3;

    logic        clk;
    logic        rst   [2];
    logic        st    [2];
    logic [31:0] dat   [2];
    logic        vld   [2];
    logic        rdy   [2];
    logic [31:0] ca    [2];
    logic [31:0] cd    [2];
    logic        en    [2];
    logic        bsy   [2];
    logic        dn    [2];
    logic        er    [2];
    logic [15:0] wd    [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit armed    = 0;

    // Model state: what the loader must look like, from the stream rules only.
    int          gapv      [2] = '{2, 0};
    int          m_phase   [2];
    int          m_want    [2];
    int          m_ready_at[2];
    int          m_pulse_at[2];
    int          m_finish  [2];
    logic [15:0] m_left    [2];
    logic [15:0] m_writes  [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_data    [2];

    int          pc0[$];
    int          pc1[$];
    logic [31:0] pa0[$];
    logic [31:0] pd0[$];
    logic [31:0] pa1[$];
    logic [31:0] pd1[$];

    config_loader #(.MAGIC(16'hC0F1), .GAP_CYCLES(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .in_data(dat[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .config_addr(ca[0]), .config_data(cd[0]), .config_en(en[0]),
        .busy(bsy[0]), .done(dn[0]), .error(er[0]), .writes_done(wd[0])
    );

    config_loader #(.MAGIC(16'hC0F1), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .in_data(dat[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .config_addr(ca[1]), .config_data(cd[1]), .config_en(en[1]),
        .busy(bsy[1]), .done(dn[1]), .error(er[1]), .writes_done(wd[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic bit exp_rdy(input int d);
        return (m_phase[d] == P_LOAD) && (cyc >= m_ready_at[d]);
    endfunction

    task automatic model_step(input int d);
        bit rd;
        rd = exp_rdy(d);
        if (rst[d]) begin
            m_phase[d] = P_IDLE;  m_want[d] = 0;      m_ready_at[d] = 0;
            m_pulse_at[d] = -1;   m_finish[d] = -1;   m_left[d] = '0;
            m_writes[d] = '0;     m_addr[d] = '0;     m_data[d] = '0;
            return;
        end
        if (m_phase[d] == P_LOAD) begin
            if (cyc == m_pulse_at[d]) m_writes[d] = m_writes[d] + 16'd1;
            if (vld[d] && rd) begin
                case (m_want[d])
                    0: begin
                        if (dat[d][31:16] != 16'hC0F1) begin
                            m_phase[d] = P_ERR;
                        end else begin
                            m_left[d] = dat[d][15:0];
                            if (m_left[d] == 16'd0) m_phase[d] = P_DONE;
                            else                    m_want[d] = 1;
                        end
                    end
                    1: begin
                        m_addr[d] = dat[d];
                        m_want[d] = 2;
                    end
                    default: begin
                        m_data[d]     = dat[d];
                        m_want[d]     = 1;
                        m_pulse_at[d] = cyc + 1;
                        m_ready_at[d] = cyc + 2 + gapv[d];
                        m_left[d]     = m_left[d] - 16'd1;
                        if (m_left[d] == 16'd0) m_finish[d] = cyc + 2 + gapv[d];
                    end
                endcase
            end
            if ((m_phase[d] == P_LOAD) && (m_finish[d] == cyc + 1)) m_phase[d] = P_DONE;
        end else if (st[d]) begin
            m_phase[d]    = P_LOAD;
            m_want[d]     = 0;
            m_ready_at[d] = cyc + 1;
            m_pulse_at[d] = -1;
            m_finish[d]   = -1;
            m_writes[d]   = '0;
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("in_ready%0d", d),    32'(rdy[d]), 32'(exp_rdy(d)));
                chk($sformatf("config_en%0d", d),   32'(en[d]),
                    32'((m_phase[d] == P_LOAD) && (cyc == m_pulse_at[d])));
                chk($sformatf("busy%0d", d),        32'(bsy[d]), 32'(m_phase[d] == P_LOAD));
                chk($sformatf("done%0d", d),        32'(dn[d]),  32'(m_phase[d] == P_DONE));
                chk($sformatf("error%0d", d),       32'(er[d]),  32'(m_phase[d] == P_ERR));
                chk($sformatf("config_addr%0d", d), ca[d], m_addr[d]);
                chk($sformatf("config_data%0d", d), cd[d], m_data[d]);
                chk($sformatf("writes_done%0d", d), 32'(wd[d]), 32'(m_writes[d]));
            end
            if (en[0] === 1'b1) begin pc0.push_back(cyc); pa0.push_back(ca[0]); pd0.push_back(cd[0]); end
            if (en[1] === 1'b1) begin pc1.push_back(cyc); pa1.push_back(ca[1]); pd1.push_back(cd[1]); end
        end
    end

    // Called at a negedge; returns at the negedge after the word transfers.
    task automatic push(input int d, input logic [31:0] w);
        int n;
        vld[d] = 1'b1;
        dat[d] = w;
        n = 0;
        while (!rdy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            checks++;
            failures++;
            $display("FAIL push_timeout dut%0d got=ready_low exp=ready_high", d);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic kick(input int d);
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; st[d] = 1'b0; vld[d] = 1'b0; dat[d] = '0;
        end
        @(posedge clk);
        #1 armed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_en",   32'(en[0]),  32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_addr", ca[0],       32'd0);
        chk("rst_wd",   32'(wd[1]),  32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Basic two-pair load, gap 2
        kick(0);
        push(0, 32'hC0F1_0002); push(0, 32'h0001_0003); push(0, 32'hDEAD_BEEF);
        push(0, 32'h0001_0004); push(0, 32'h0000_00A5);
        vld[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("basic_pulses", 32'(pc0.size()), 32'd2);
        if (pc0.size() >= 2) begin
            chk("basic_addr0", pa0[0], 32'h0001_0003);
            chk("basic_data0", pd0[0], 32'hDEAD_BEEF);
            chk("basic_addr1", pa0[1], 32'h0001_0004);
            chk("basic_data1", pd0[1], 32'h0000_00A5);
            chk("basic_spacing", 32'(pc0[1] - pc0[0]), 32'd5);
        end
        chk("basic_wd",   32'(wd[0]),  32'd2);
        chk("basic_done", 32'(dn[0]),  32'd1);
        chk("basic_busy", 32'(bsy[0]), 32'd0);
        chk("model_wd",   32'(m_writes[0]), 32'd2);

        // Bad magic, then restart with in_valid already high
        kick(0);
        push(0, 32'h1234_0001);
        chk("bad_error", 32'(er[0]),  32'd1);
        chk("bad_ready", 32'(rdy[0]), 32'd0);
        dat[0] = 32'hC0F1_0001;
        repeat (3) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        chk("restart_error", 32'(er[0]),  32'd0);
        chk("restart_busy",  32'(bsy[0]), 32'd1);
        push(0, 32'hC0F1_0001); push(0, 32'h0002_0007); push(0, 32'h1111_2222);
        vld[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("restart_done", 32'(dn[0]), 32'd1);
        chk("restart_wd",   32'(wd[0]), 32'd1);
        chk("restart_data", cd[0],      32'h1111_2222);

        // Zero-pair header
        kick(0);
        n = pc0.size();
        push(0, 32'hC0F1_0000);
        vld[0] = 1'b0;
        chk("zero_done", 32'(dn[0]), 32'd1);
        chk("zero_wd",   32'(wd[0]), 32'd0);
        @(negedge clk);
        chk("zero_no_en", 32'(pc0.size()), 32'(n));

        // Stall between address and data words
        kick(0);
        push(0, 32'hC0F1_0001); push(0, 32'h0003_0042);
        vld[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_addr_hold", ca[0], 32'h0003_0042);
        push(0, 32'h5555_AAAA);
        vld[0] = 1'b0;
        chk("bp_en_next", 32'(en[0]), 32'd1);
        chk("bp_addr",    ca[0],      32'h0003_0042);
        chk("bp_data",    cd[0],      32'h5555_AAAA);
        repeat (4) @(negedge clk);

        // Reset in the gap after the first of three pairs
        kick(0);
        push(0, 32'hC0F1_0003); push(0, 32'h0004_0001); push(0, 32'h0000_0011);
        dat[0] = 32'h0005_0002;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("mid_rst_en",    32'(en[0]),  32'd0);
        chk("mid_rst_busy",  32'(bsy[0]), 32'd0);
        chk("mid_rst_ready", 32'(rdy[0]), 32'd0);
        chk("mid_rst_addr",  ca[0],       32'd0);
        chk("mid_rst_data",  cd[0],       32'd0);
        chk("mid_rst_wd",    32'(wd[0]),  32'd0);
        rst[0] = 1'b0;
        n = pc0.size();
        repeat (8) @(negedge clk);
        chk("mid_rst_no_en", 32'(pc0.size()), 32'(n));
        vld[0] = 1'b0;

        // Zero-gap burst of three pairs with a start mid-load
        kick(1);
        push(1, 32'hC0F1_0003); push(1, 32'h0001_0001); push(1, 32'h0000_00A1);
        st[1] = 1'b1;
        push(1, 32'h0002_0002); push(1, 32'h0000_00B2);
        st[1] = 1'b0;
        push(1, 32'h0003_0003); push(1, 32'h0000_00C3);
        vld[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("g0_pulses", 32'(pc1.size()), 32'd3);
        if (pc1.size() >= 3) begin
            chk("g0_spacing01", 32'(pc1[1] - pc1[0]), 32'd3);
            chk("g0_spacing12", 32'(pc1[2] - pc1[1]), 32'd3);
            chk("g0_addr2",     pa1[2], 32'h0003_0003);
            chk("g0_data2",     pd1[2], 32'h0000_00C3);
        end
        chk("g0_wd",   32'(wd[1]), 32'd3);
        chk("g0_done", 32'(dn[1]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
